// File: rtl/reverse_axi_slv_mem.sv
// AXI3 burst slave on on-chip RAM standing in for host memory behind the reverse top.
// One transaction in flight, fair write/read arbitration, SLVERR on unsupported requests.
module reverse_axi_slv_mem #(
    parameter int AXI_DW    = 512,
    parameter int AXI_AW    = 64,
    parameter int AXI_SIDW  = 1,
    parameter int MEM_DEPTH = 64
) (
    input  logic                  axi_clk,
    input  logic                  axi_rst,
    input  logic [AXI_SIDW-1:0]   s_awid,
    input  logic [AXI_AW-1:0]     s_awaddr,
    input  logic [3:0]            s_awlen,
    input  logic [2:0]            s_awsize,
    input  logic [1:0]            s_awburst,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [AXI_DW-1:0]     s_wdata,
    input  logic [AXI_DW/8-1:0]   s_wstrb,
    input  logic                  s_wlast,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [AXI_SIDW-1:0]   s_bid,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [AXI_SIDW-1:0]   s_arid,
    input  logic [AXI_AW-1:0]     s_araddr,
    input  logic [3:0]            s_arlen,
    input  logic [2:0]            s_arsize,
    input  logic [1:0]            s_arburst,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [AXI_SIDW-1:0]   s_rid,
    output logic [AXI_DW-1:0]     s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    output logic                  s_rvalid,
    input  logic                  s_rready
);

    localparam int BYTES = AXI_DW / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int WA_W  = $clog2(MEM_DEPTH);

    localparam logic [2:0]        SIZE_FULL   = 3'(OFF_W);
    localparam logic [AXI_AW-1:0] MEM_BYTES   = AXI_AW'(MEM_DEPTH) * AXI_AW'(BYTES);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;
    localparam logic [1:0]        BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_DATA
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                prio_wr;
    logic [AXI_SIDW-1:0] cur_id;
    logic [3:0]          cur_len;
    logic                cur_fixed;
    logic [WA_W-1:0]     cur_addr;
    logic                err;
    logic [3:0]          cnt;
    logic                rd_done;

    logic                aw_hs;
    logic                ar_hs;
    logic                w_hs;
    logic                last_beat;
    logic                wlast_bad;
    logic                rd_en;
    logic                rd_issue;

    logic [AXI_DW-1:0]   mem [MEM_DEPTH];

    // WRAP and reserved bursts, narrow/wide sizes and addresses past the RAM all get SLVERR.
    function automatic logic req_err(input logic [1:0] burst, input logic [2:0] size,
                                     input logic [AXI_AW-1:0] addr);
        return burst[1] || (size != SIZE_FULL) || (addr >= MEM_BYTES);
    endfunction

    assign aw_hs     = s_awvalid && s_awready;
    assign ar_hs     = s_arvalid && s_arready;
    assign w_hs      = s_wvalid && s_wready;
    assign last_beat = (cnt == cur_len);
    assign wlast_bad = (s_wlast != last_beat);
    assign rd_en     = !s_rvalid || s_rready;
    assign rd_issue  = (state == RD_DATA) && !rd_done;

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_awready = 1'b0;
        s_arready = 1'b0;
        s_wready  = 1'b0;
        if (!axi_rst) begin
            case (state)
                IDLE: begin
                    s_awready = s_awvalid && (!s_arvalid || prio_wr);
                    s_arready = s_arvalid && (!s_awvalid || !prio_wr);
                    if (s_awready) begin
                        state_nxt = WR_DATA;
                    end else if (s_arready) begin
                        state_nxt = RD_DATA;
                    end
                end
                WR_DATA: begin
                    s_wready = 1'b1;
                    if (s_wvalid && last_beat) begin
                        state_nxt = WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (s_bvalid && s_bready) begin
                        state_nxt = IDLE;
                    end
                end
                RD_DATA: begin
                    if (s_rvalid && s_rready && s_rlast) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            prio_wr   <= 1'b1;
            cur_id    <= '0;
            cur_len   <= '0;
            cur_fixed <= 1'b0;
            cur_addr  <= '0;
            err       <= 1'b0;
            cnt       <= '0;
            rd_done   <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bid     <= '0;
            s_bresp   <= RESP_OKAY;
            s_rvalid  <= 1'b0;
            s_rlast   <= 1'b0;
            s_rid     <= '0;
            s_rresp   <= RESP_OKAY;
            s_rdata   <= '0;
        end else begin
            if (aw_hs || ar_hs) begin
                // Next contention goes to the side that was not just served.
                prio_wr   <= ar_hs;
                cnt       <= '0;
                rd_done   <= 1'b0;
                if (aw_hs) begin
                    cur_id    <= s_awid;
                    cur_len   <= s_awlen;
                    cur_fixed <= (s_awburst == BURST_FIXED);
                    cur_addr  <= s_awaddr[OFF_W +: WA_W];
                    err       <= req_err(s_awburst, s_awsize, s_awaddr);
                end else begin
                    cur_id    <= s_arid;
                    cur_len   <= s_arlen;
                    cur_fixed <= (s_arburst == BURST_FIXED);
                    cur_addr  <= s_araddr[OFF_W +: WA_W];
                    err       <= req_err(s_arburst, s_arsize, s_araddr);
                end
            end

            if (w_hs) begin
                cnt <= cnt + 4'd1;
                if (!cur_fixed) begin
                    cur_addr <= cur_addr + WA_W'(1);
                end
                if (wlast_bad) begin
                    err <= 1'b1;
                end
                if (last_beat) begin
                    s_bvalid <= 1'b1;
                    s_bid    <= cur_id;
                    s_bresp  <= (err || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                end
            end

            if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
            end

            // A stalled beat keeps rdata/rlast/rresp frozen because the RAM read is gated by rd_en.
            if (rd_en) begin
                if (rd_issue) begin
                    s_rvalid <= 1'b1;
                    s_rdata  <= err ? '0 : mem[cur_addr];
                    s_rlast  <= last_beat;
                    s_rid    <= cur_id;
                    s_rresp  <= err ? RESP_SLVERR : RESP_OKAY;
                    cnt      <= cnt + 4'd1;
                    if (!cur_fixed) begin
                        cur_addr <= cur_addr + WA_W'(1);
                    end
                    if (last_beat) begin
                        rd_done <= 1'b1;
                    end
                end else begin
                    s_rvalid <= 1'b0;
                    s_rlast  <= 1'b0;
                end
            end
        end
    end

    // NOTE: the RAM array has no reset so it maps onto block RAM; contents survive axi_rst.
    always_ff @(posedge axi_clk) begin
        if (w_hs && !err) begin
            for (int i = 0; i < BYTES; i++) begin
                if (s_wstrb[i]) begin
                    mem[cur_addr][8*i +: 8] <= s_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_reverse_axi_slv_mem.sv
// Directed bench for reverse_axi_slv_mem: bursts, strobes, backpressure, errors,
// arbitration and mid-burst reset, all checked against hand-computed values.
module tb_reverse_axi_slv_mem;

    localparam int DW    = 512;
    localparam int AW    = 64;
    localparam int IDW   = 1;
    localparam int DEPTH = 64;
    localparam int SB    = DW / 8;
    localparam int TMO   = 50;

    logic            axi_clk = 1'b0;
    logic            axi_rst;
    logic [IDW-1:0]  s_awid;
    logic [AW-1:0]   s_awaddr;
    logic [3:0]      s_awlen;
    logic [2:0]      s_awsize;
    logic [1:0]      s_awburst;
    logic            s_awvalid;
    logic            s_awready;
    logic [DW-1:0]   s_wdata;
    logic [SB-1:0]   s_wstrb;
    logic            s_wlast;
    logic            s_wvalid;
    logic            s_wready;
    logic [IDW-1:0]  s_bid;
    logic [1:0]      s_bresp;
    logic            s_bvalid;
    logic            s_bready;
    logic [IDW-1:0]  s_arid;
    logic [AW-1:0]   s_araddr;
    logic [3:0]      s_arlen;
    logic [2:0]      s_arsize;
    logic [1:0]      s_arburst;
    logic            s_arvalid;
    logic            s_arready;
    logic [IDW-1:0]  s_rid;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic            s_rvalid;
    logic            s_rready;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0]  wr_data  [16];
    logic [SB-1:0]  wr_strb  [16];
    logic [DW-1:0]  rd_data  [16];
    logic [1:0]     rd_resp  [16];
    logic           rd_last  [16];
    logic [IDW-1:0] rd_id    [16];
    logic [DW-1:0]  exp_data [16];

    reverse_axi_slv_mem #(
        .AXI_DW(DW), .AXI_AW(AW), .AXI_SIDW(IDW), .MEM_DEPTH(DEPTH)
    ) dut (
        .axi_clk(axi_clk), .axi_rst(axi_rst),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 axi_clk = ~axi_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end of test, expected $finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All phase tasks start and end just after a falling edge.
    task automatic aw_phase(input logic [IDW-1:0] id, input int word, input int len,
                            input logic [1:0] burst, output int waited);
        s_awid = id; s_awaddr = AW'(word * SB); s_awlen = 4'(len);
        s_awsize = 3'd6; s_awburst = burst; s_awvalid = 1'b1;
        waited = 0;
        #1;
        while (!s_awready && waited < TMO) begin
            @(negedge axi_clk); #1; waited++;
        end
        check("aw_ready", s_awready, 1);
        @(posedge axi_clk); @(negedge axi_clk);
        s_awvalid = 1'b0;
    endtask

    task automatic ar_phase(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input int len,
                            output int waited);
        s_arid = id; s_araddr = addr; s_arlen = 4'(len);
        s_arsize = 3'd6; s_arburst = 2'b01; s_arvalid = 1'b1;
        waited = 0;
        #1;
        while (!s_arready && waited < TMO) begin
            @(negedge axi_clk); #1; waited++;
        end
        check("ar_ready", s_arready, 1);
        @(posedge axi_clk); @(negedge axi_clk);
        s_arvalid = 1'b0;
    endtask

    task automatic w_phase(input int len, input int early, output logic [1:0] resp,
                           output logic [IDW-1:0] bid);
        int n;
        for (int b = 0; b <= len; b++) begin
            s_wdata = wr_data[b]; s_wstrb = wr_strb[b];
            s_wlast = (b == len) || (b == early); s_wvalid = 1'b1;
            n = 0;
            #1;
            while (!s_wready && n < TMO) begin
                @(negedge axi_clk); #1; n++;
            end
            check("w_ready", s_wready, 1);
            @(posedge axi_clk); @(negedge axi_clk);
        end
        s_wvalid = 1'b0; s_wlast = 1'b0; s_bready = 1'b1;
        n = 0;
        #1;
        while (!s_bvalid && n < TMO) begin
            @(negedge axi_clk); #1; n++;
        end
        check("b_valid", s_bvalid, 1);
        resp = s_bresp; bid = s_bid;
        @(posedge axi_clk); @(negedge axi_clk);
        s_bready = 1'b0;
        #1;
        check("b_drop", s_bvalid, 0);
    endtask

    task automatic r_phase(input int len, input bit toggle, output int nb);
        int cyc = 0;
        int first = -1;
        bit stalled = 1'b0;
        logic [DW-1:0] held = '0;
        nb = 0;
        while (nb <= len && cyc < TMO) begin
            s_rready = toggle ? (((cyc / 2) % 2) == 0) : 1'b1;
            #1;
            if (s_rvalid) begin
                if (first < 0) first = cyc;
                if (stalled) check("r_hold", s_rdata, held);
                if (s_rready) begin
                    rd_data[nb] = s_rdata; rd_resp[nb] = s_rresp;
                    rd_last[nb] = s_rlast; rd_id[nb] = s_rid;
                    nb++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = s_rdata;
                end
            end
            @(posedge axi_clk); @(negedge axi_clk);
            cyc++;
        end
        s_rready = 1'b0;
        check("r_beats", nb, len + 1);
        check("r_latency", first, 1);
        #1;
        check("r_drop", s_rvalid, 0);
    endtask

    task automatic verify_rd(input string tag, input int len, input logic [IDW-1:0] id,
                             input logic [1:0] resp);
        for (int i = 0; i <= len; i++) begin
            check({tag, "_data"}, rd_data[i], exp_data[i]);
            check({tag, "_last"}, rd_last[i], i == len);
            check({tag, "_resp"}, rd_resp[i], resp);
            check({tag, "_id"}, rd_id[i], id);
        end
    endtask

    task automatic do_write(input logic [IDW-1:0] id, input int word, input int len,
                            input logic [1:0] burst, input int early, output logic [1:0] resp,
                            output logic [IDW-1:0] bid);
        int w;
        aw_phase(id, word, len, burst, w);
        w_phase(len, early, resp, bid);
    endtask

    task automatic do_read(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input int len,
                           input bit toggle);
        int w;
        int nb;
        ar_phase(id, addr, len, w);
        r_phase(len, toggle, nb);
    endtask

    initial begin
        logic [1:0]     resp;
        logic [IDW-1:0] bid;
        int             waited;
        int             nb;
        int             cyc;
        bit             got_w;

        axi_rst = 1'b1;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = 3'd6; s_awburst = 2'b01; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = 3'd6; s_arburst = 2'b01; s_arvalid = 1'b0;
        s_rready = 1'b0;
        repeat (3) @(negedge axi_clk);

        // Reset state, and address readies gated while reset is high.
        s_awvalid = 1'b1; s_arvalid = 1'b1;
        #1;
        check("rst_awready", s_awready, 0);
        check("rst_arready", s_arready, 0);
        check("rst_wready", s_wready, 0);
        check("rst_bvalid", s_bvalid, 0);
        check("rst_rvalid", s_rvalid, 0);
        check("rst_rlast", s_rlast, 0);
        check("rst_bresp", s_bresp, 0);
        check("rst_rresp", s_rresp, 0);
        check("rst_bid", s_bid, 0);
        check("rst_rid", s_rid, 0);
        check("rst_rdata", s_rdata, 0);
        s_awvalid = 1'b0; s_arvalid = 1'b0;
        @(negedge axi_clk);
        axi_rst = 1'b0;
        @(negedge axi_clk);

        // INCR write then read back.
        for (int i = 0; i < 4; i++) begin
            wr_data[i] = DW'('hA0 + i); wr_strb[i] = '1; exp_data[i] = DW'('hA0 + i);
        end
        do_write(1'b1, 0, 3, 2'b01, -1, resp, bid);
        check("incr_bresp", resp, 2'b00);
        check("incr_bid", bid, 1'b1);
        do_read(1'b1, 0, 3, 1'b0);
        verify_rd("incr", 3, 1'b1, 2'b00);

        // Strobe merge on word 5.
        wr_data[0] = '1; wr_strb[0] = '1;
        do_write(1'b0, 5, 0, 2'b01, -1, resp, bid);
        wr_data[0] = '0; wr_strb[0] = SB'('hF);
        do_write(1'b0, 5, 0, 2'b01, -1, resp, bid);
        check("strb_bresp", resp, 2'b00);
        exp_data[0] = {{(DW-32){1'b1}}, 32'h0};
        do_read(1'b0, 5 * SB, 0, 1'b0);
        verify_rd("strb", 0, 1'b0, 2'b00);

        // Eight-beat read under rready backpressure.
        for (int i = 0; i < 8; i++) begin
            wr_data[i] = DW'('h100 + i); wr_strb[i] = '1; exp_data[i] = DW'('h100 + i);
        end
        do_write(1'b1, 8, 7, 2'b01, -1, resp, bid);
        check("bp_bresp", resp, 2'b00);
        do_read(1'b0, 8 * SB, 7, 1'b1);
        verify_rd("bp", 7, 1'b0, 2'b00);

        // WRAP write is rejected and leaves RAM alone.
        wr_data[0] = DW'('hDEAD); wr_strb[0] = '1;
        do_write(1'b0, 0, 0, 2'b10, -1, resp, bid);
        check("wrap_bresp", resp, 2'b10);
        exp_data[0] = DW'('hA0);
        do_read(1'b0, 0, 0, 1'b0);
        verify_rd("wrap_ram", 0, 1'b0, 2'b00);

        // Out-of-range read: SLVERR beats with zero data.
        for (int i = 0; i < 3; i++) exp_data[i] = '0;
        do_read(1'b1, AW'(DEPTH * SB), 2, 1'b0);
        verify_rd("oor", 2, 1'b1, 2'b10);

        // Early wlast on beat 1 of four: all four consumed, SLVERR.
        for (int i = 0; i < 4; i++) begin
            wr_data[i] = DW'('h700 + i); wr_strb[i] = '1;
        end
        do_write(1'b1, 20, 3, 2'b01, 1, resp, bid);
        check("early_bresp", resp, 2'b10);
        check("early_bid", bid, 1'b1);

        // FIXED burst keeps hitting one word.
        wr_data[0] = DW'('h30); wr_data[1] = DW'('h31);
        do_write(1'b0, 30, 1, 2'b01, -1, resp, bid);
        wr_data[0] = DW'(1); wr_data[1] = DW'(2); wr_data[2] = DW'(3);
        do_write(1'b0, 30, 2, 2'b00, -1, resp, bid);
        check("fixed_bresp", resp, 2'b00);
        exp_data[0] = DW'(3); exp_data[1] = DW'('h31);
        do_read(1'b0, 30 * SB, 1, 1'b0);
        verify_rd("fixed", 1, 1'b0, 2'b00);

        // Reset while beat 2 of an eight-beat read is on the bus.
        ar_phase(1'b0, 8 * SB, 7, waited);
        s_rready = 1'b1; nb = 0; cyc = 0;
        while (nb < 2 && cyc < TMO) begin
            #1;
            if (s_rvalid) begin
                check("mid_pre_data", s_rdata, DW'('h100 + nb));
                nb++;
            end
            @(negedge axi_clk);
            cyc++;
        end
        #1;
        check("mid_beat2_valid", s_rvalid, 1);
        axi_rst = 1'b1;
        @(posedge axi_clk); #1;
        check("mid_rst_rvalid", s_rvalid, 0);
        check("mid_rst_rlast", s_rlast, 0);
        @(negedge axi_clk);
        axi_rst = 1'b0; s_rready = 1'b0;
        ar_phase(1'b1, 3 * SB, 0, waited);
        check("mid_idle_grant", waited, 0);
        r_phase(0, 1'b0, nb);
        exp_data[0] = DW'('hA3);
        verify_rd("mid_after", 0, 1'b1, 2'b00);

        // Simultaneous requests after a fresh reset: W, R, W, R.
        axi_rst = 1'b1;
        @(negedge axi_clk); @(negedge axi_clk);
        axi_rst = 1'b0;
        @(negedge axi_clk);
        for (int k = 0; k < 4; k++) begin
            s_awid = 1'b0; s_awaddr = AW'((40 + k / 2) * SB); s_awlen = 4'd0;
            s_awsize = 3'd6; s_awburst = 2'b01;
            s_arid = 1'b1; s_araddr = AW'(8 * SB); s_arlen = 4'd0;
            s_arsize = 3'd6; s_arburst = 2'b01;
            s_awvalid = 1'b1; s_arvalid = 1'b1;
            waited = 0;
            #1;
            while (!(s_awready || s_arready) && waited < TMO) begin
                @(negedge axi_clk); #1; waited++;
            end
            check("arb_grant", {s_awready, s_arready}, (k % 2 == 0) ? 2'b10 : 2'b01);
            got_w = s_awready;
            @(posedge axi_clk); @(negedge axi_clk);
            s_awvalid = 1'b0; s_arvalid = 1'b0;
            if (got_w) begin
                wr_data[0] = DW'('h500 + k); wr_strb[0] = '1;
                w_phase(0, -1, resp, bid);
                check("arb_bresp", resp, 2'b00);
            end else begin
                r_phase(0, 1'b0, nb);
                check("arb_rdata", rd_data[0], DW'('h100));
            end
        end
        exp_data[0] = DW'('h500); exp_data[1] = DW'('h502);
        do_read(1'b0, 40 * SB, 1, 1'b0);
        verify_rd("arb_ram", 1, 1'b0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
